// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI SRAM slave: burst and response codes and the
// transaction FSM state encoding.
package axi_sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // IDLE: waiting for AR/AW; RD: read burst; WR: write data; WB: write response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus bundle between a master and the SRAM slave.
// Ports: AR, R, AW, W and B channels; slave modport for the memory, master
// modport for whoever drives it.
//
// Handshake: every channel transfers on a rising clock edge where valid and
// ready are both 1. A source holds valid and its payload stable until that
// transfer; ready may depend on valid.
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_sram_slave_sram_bytewrite.sv
// Single-port synchronous RAM of 2**MEM_AW 32-bit words with per-byte writes.
// Ports: clk, rst (clears only the read register), en, we[3:0] byte enables,
// addr (word address), wdata, rdata (registered, one cycle latency).
module sram_bytewrite #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Only a pure read (no byte enables) refreshes rdata, so it holds across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (en && we == 4'b0000) rdata <= mem[addr];
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style slave in front of a byte-writable SRAM. One transaction at a
// time, INCR/FIXED bursts (WRAP treated as INCR), one beat per cycle.
// Ports: clk, rst (async, active high), bus (slave modport of
// axi_sram_slave_if), dbg_state (current FSM state).
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    axi_sram_slave_if.slave bus,
    output state_t          dbg_state
);
    state_t            state_q, state_d;
    logic              prio_wr_q;   // 1: write channel wins the next AR/AW collision
    logic [ID_W-1:0]   id_q;
    logic [MEM_AW-1:0] addr_q, addr_step;
    logic [8:0]        cnt_q;       // RD: reads left to issue; WR: beats left minus one
    logic [1:0]        burst_q;
    logic              rvalid_q, rlast_q;

    logic ar_sel, aw_sel, idle, ar_hs, aw_hs, rd_en, r_hs, w_hs;
    logic [31:0] sram_rdata;

    always_comb begin
        ar_sel    = bus.arvalid & (~bus.awvalid | ~prio_wr_q);
        aw_sel    = bus.awvalid & (~bus.arvalid |  prio_wr_q);
        idle      = (state_q == ST_IDLE) & ~rst;
        ar_hs     = idle & ar_sel;
        aw_hs     = idle & aw_sel;
        // Issue a read whenever the output slot is free or being drained.
        rd_en     = (state_q == ST_RD) & (~rvalid_q | bus.rready) & (cnt_q != 9'd0);
        r_hs      = rvalid_q & bus.rready;
        w_hs      = (state_q == ST_WR) & bus.wvalid;
        addr_step = (burst_q == BURST_FIXED) ? addr_q : addr_q + MEM_AW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ar_hs) state_d = ST_RD;
                     else if (aw_hs) state_d = ST_WR;
            ST_RD:   if (r_hs && rlast_q) state_d = ST_IDLE;
            ST_WR:   if (w_hs && cnt_q == 9'd0) state_d = ST_WB;
            ST_WB:   if (bus.bready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            burst_q   <= BURST_INCR;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_q    <= bus.arid;
                addr_q  <= bus.araddr[MEM_AW+1:2];
                cnt_q   <= {1'b0, bus.arlen} + 9'd1;
                burst_q <= bus.arburst;
                if (bus.awvalid) prio_wr_q <= 1'b1;
            end
            if (aw_hs) begin
                id_q    <= bus.awid;
                addr_q  <= bus.awaddr[MEM_AW+1:2];
                cnt_q   <= {5'b0, bus.awlen};
                burst_q <= bus.awburst;
                if (bus.arvalid) prio_wr_q <= 1'b0;
            end
            if (rd_en || (w_hs && cnt_q != 9'd0)) begin
                addr_q <= addr_step;
                cnt_q  <= cnt_q - 9'd1;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (cnt_q == 9'd1);
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    sram_bytewrite #(.MEM_AW(MEM_AW)) u_sram (
        .clk   (clk),
        .rst   (rst),
        .en    (rd_en | w_hs),
        .we    (w_hs ? bus.wstrb : 4'b0000),
        .addr  (addr_q),
        .wdata (bus.wdata),
        .rdata (sram_rdata)
    );

    assign bus.arready = ar_hs;
    assign bus.awready = aw_hs;
    assign bus.rid     = id_q;
    assign bus.rdata   = sram_rdata;
    assign bus.rresp   = RESP_OKAY;
    assign bus.rlast   = rlast_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.wready  = (state_q == ST_WR);
    assign bus.bid     = id_q;
    assign bus.bresp   = RESP_OKAY;
    assign bus.bvalid  = (state_q == ST_WB);
    assign dbg_state   = state_q;

    // Size, wlast and out-of-range address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.araddr[31:MEM_AW+2], bus.araddr[1:0], bus.arsize,
                           bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0], bus.awsize,
                           bus.wlast};

endmodule
